// File: rtl/two_bit_counter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// two_bit_counter_pkg : count modes and Gray-ring successor for two_bit_counter
// Rev 1.0
// ----------------------------------------------------------------------------
package two_bit_counter_pkg;

  localparam int unsigned COUNT_W = 2;

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_GRAY = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  // Ring order 00 -> 01 -> 11 -> 10 -> 00; any value is a valid entry point.
  function automatic logic [COUNT_W-1:0] gray_next(input logic [COUNT_W-1:0] cur);
    logic [COUNT_W-1:0] nxt;
    case (cur)
      2'b00:   nxt = 2'b01;
      2'b01:   nxt = 2'b11;
      2'b11:   nxt = 2'b10;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/two_bit_counter_next.sv
`default_nettype none
// ----------------------------------------------------------------------------
// two_bit_counter_next : combinational next-state for the 2-bit counter
// Rev 1.0
// ----------------------------------------------------------------------------
module two_bit_counter_next
  import two_bit_counter_pkg::*;
(
  input  logic [COUNT_W-1:0] count,
  input  logic               en,
  input  logic [1:0]         select,
  output logic [COUNT_W-1:0] count_next
);

  always_comb begin
    count_next = count;
    if (en) begin
      case (mode_e'(select))
        MODE_UP:   count_next = count + 2'd1;
        MODE_DOWN: count_next = count - 2'd1;
        MODE_GRAY: count_next = gray_next(count);
        default:   count_next = count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/two_bit_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// two_bit_counter : 2-bit up/down/Gray/hold counter with registered match flag
// Rev 1.0
// ----------------------------------------------------------------------------
module two_bit_counter
  import two_bit_counter_pkg::*;
#(
  parameter logic [COUNT_W-1:0] RESET_VALUE = 2'b00
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               En,
  input  logic [1:0]         select,
  input  logic [COUNT_W-1:0] Counter_Out,
  output logic               out1
);

  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;
  logic               out1_q;
  logic               out1_d;

  two_bit_counter_next u_next (
    .count      (count_q),
    .en         (En),
    .select     (select),
    .count_next (count_d)
  );

  // Compare against the value being loaded, so the flag lines up with the new count.
  always_comb begin
    out1_d = En & (count_d == Counter_Out);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      count_q <= RESET_VALUE;
      out1_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      out1_q  <= out1_d;
    end
  end

  assign out1 = out1_q;

endmodule
`default_nettype wire

// File: tb/tb_two_bit_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_two_bit_counter : directed and random checks of out1 against a ring model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_two_bit_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] sel;
  logic [1:0] tgt;
  logic       out1;

  int checks   = 0;
  int failures = 0;

  int m_count  = 0;
  int m_out1   = 0;
  bit m_valid  = 0;

  two_bit_counter #(.RESET_VALUE(2'b00)) dut (
    .Clk         (clk),
    .Reset       (rst_n),
    .En          (en),
    .select      (sel),
    .Counter_Out (tgt),
    .out1        (out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_next(input int c, input int mode);
    int ring [4] = '{0, 1, 3, 2};
    int pos = 0;
    case (mode)
      0: return (c + 1) % 4;
      1: return (c + 3) % 4;
      2: begin
        for (int k = 0; k < 4; k++) if (ring[k] == c) pos = k;
        return ring[(pos + 1) % 4];
      end
      default: return c;
    endcase
  endfunction

  always @(posedge clk) begin
    int nxt;
    if (!rst_n) begin
      m_count = 0;
      m_out1  = 0;
      m_valid = 1;
    end else if (m_valid) begin
      nxt     = en ? model_next(m_count, int'(sel)) : m_count;
      m_out1  = (en && nxt == int'(tgt)) ? 1 : 0;
      m_count = nxt;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if (int'(out1) != m_out1) begin
        failures++;
        $display("FAIL cycle_out1 t=%0t out1=%0d expected=%0d", $time, out1, m_out1);
      end
    end
  end

  // Apply inputs at the falling edge, then check after the rising edge.
  task automatic step(input logic r, input logic e, input logic [1:0] s,
                      input logic [1:0] t, input int exp, input string name);
    @(negedge clk);
    rst_n = r; en = e; sel = s; tgt = t;
    @(posedge clk);
    #1;
    if (exp >= 0) begin
      checks++;
      if (int'(out1) != exp || m_out1 != exp) begin
        failures++;
        $display("FAIL %s out1=%0d model=%0d expected=%0d", name, out1, m_out1, exp);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; sel = 2'b00; tgt = 2'b00;

    repeat (3) step(0, 1, 2'b00, 2'd0, 0, "reset_hold");
    step(1, 1, 2'b00, 2'd0, 0, "release_first_up");

    step(0, 1, 2'b00, 2'd2, 0, "reset_before_up");
    step(1, 1, 2'b00, 2'd2, 0, "up_to1");
    step(1, 1, 2'b00, 2'd2, 1, "up_to2_match");
    step(1, 1, 2'b00, 2'd2, 0, "up_to3");
    step(1, 1, 2'b00, 2'd2, 0, "up_wrap0");
    step(1, 1, 2'b00, 2'd2, 0, "up_lap2_1");
    step(1, 1, 2'b00, 2'd2, 1, "up_lap2_match");

    step(0, 1, 2'b01, 2'd3, 0, "reset_before_down");
    step(1, 1, 2'b01, 2'd3, 1, "down_wrap3_match");
    step(1, 1, 2'b01, 2'd3, 0, "down_to2");
    step(1, 1, 2'b01, 2'd3, 0, "down_to1");
    step(1, 1, 2'b01, 2'd3, 0, "down_to0");

    step(1, 1, 2'b10, 2'd2, 0, "gray_01");
    step(1, 1, 2'b10, 2'd2, 0, "gray_11");
    step(1, 1, 2'b10, 2'd2, 1, "gray_10_match");
    step(1, 1, 2'b10, 2'd2, 0, "gray_00");

    step(1, 1, 2'b00, 2'd0, 0, "up_to1_prep");
    repeat (4) step(1, 0, 2'b00, 2'd1, 0, "en_low_freeze");
    repeat (3) step(1, 1, 2'b11, 2'd1, 1, "hold_match");
    step(1, 1, 2'b11, 2'd2, 0, "hold_target_moved");
    step(1, 1, 2'b10, 2'd3, 1, "gray_entry_from_01");
    step(1, 1, 2'b00, 2'd0, 1, "up_wrap_to_target0");

    step(1, 1, 2'b00, 2'd0, 0, "up_1");
    step(1, 1, 2'b00, 2'd0, 0, "up_2");
    step(1, 1, 2'b00, 2'd0, 0, "up_3");
    step(0, 1, 2'b00, 2'd0, 0, "reset_mid_no_pulse");
    step(1, 1, 2'b00, 2'd1, 1, "after_reset_up1");

    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 15) != 0), 1'($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), -1, "random");
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
